// File: rtl/jstk_dir_decoder.sv
// Joystick direction decoder: per-axis hysteretic zoning, debounce and move-event FSM.
// Optional auto-repeat of move pulses while the stick is held: define JSTK_AUTOREPEAT_EN.
module jstk_dir_decoder #(
  parameter int DATA_W     = 10,
  parameter int CENTER     = 512,
  parameter int DEAD       = 128,
  parameter int HYST       = 16,
  parameter int STABLE_N   = 3,
  parameter int REPEAT_DLY = 4,
  parameter int REPEAT_PER = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] x_raw,
  input  logic [DATA_W-1:0] y_raw,
  output logic [2:0]        dir,
  output logic              move_pulse,
  output logic [1:0]        move_dir
);

  if (CENTER + DEAD > (2 ** DATA_W) - 1) begin : gBadHigh
    $error("jstk_dir_decoder: CENTER+DEAD exceeds the sample range");
  end
  if (CENTER < DEAD) begin : gBadLow
    $error("jstk_dir_decoder: CENTER must be >= DEAD");
  end
  if (HYST < 0 || HYST >= DEAD) begin : gBadHyst
    $error("jstk_dir_decoder: HYST must satisfy 0 <= HYST < DEAD");
  end
  if (STABLE_N < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : gBadCounts
    $error("jstk_dir_decoder: STABLE_N, REPEAT_DLY and REPEAT_PER must be >= 1");
  end

  localparam int CNT_W = $clog2(STABLE_N + 1);

  localparam logic [DATA_W:0] HI_TH  = (DATA_W+1)'(CENTER + DEAD);
  localparam logic [DATA_W:0] LO_TH  = (DATA_W+1)'(CENTER - DEAD);
  localparam logic [DATA_W:0] HI_RET = (DATA_W+1)'(CENTER + DEAD - HYST);
  localparam logic [DATA_W:0] LO_RET = (DATA_W+1)'(CENTER - DEAD + HYST);

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_DOWN  = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_NONE  = 3'd4;

  typedef enum logic [1:0] {ZONE_MID, ZONE_HI, ZONE_LO} zone_t;
  typedef enum logic [1:0] {IDLE, HOLD_DLY, HOLD_REP} state_t;

  zone_t             xZone, yZone;
  logic              evalPending;
  logic [2:0]        cand, lastCand, lastCandNext, dirNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  state_t            state, stateNext;
  logic              pulseNext;
  logic [1:0]        moveDirNext;

  // Leaving an outer zone toward centre needs HYST extra travel; a full swing jumps straight across.
  function automatic zone_t nextZone(input zone_t cur, input logic [DATA_W-1:0] raw);
    logic [DATA_W:0] v;
    zone_t           z;
    v = {1'b0, raw};
    z = cur;
    case (cur)
      ZONE_HI: begin
        if (v < LO_TH)       z = ZONE_LO;
        else if (v < HI_RET) z = ZONE_MID;
      end
      ZONE_LO: begin
        if (v > HI_TH)       z = ZONE_HI;
        else if (v > LO_RET) z = ZONE_MID;
      end
      default: begin
        if (v > HI_TH)      z = ZONE_HI;
        else if (v < LO_TH) z = ZONE_LO;
        else                z = ZONE_MID;
      end
    endcase
    return z;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      xZone       <= ZONE_MID;
      yZone       <= ZONE_MID;
      evalPending <= 1'b0;
    end else begin
      evalPending <= sample_valid;
      if (sample_valid) begin
        xZone <= nextZone(xZone, x_raw);
        yZone <= nextZone(yZone, y_raw);
      end
    end
  end

  always_comb begin
    cand = DIR_NONE;
    if (xZone == ZONE_MID && yZone == ZONE_HI)      cand = DIR_UP;
    else if (xZone == ZONE_MID && yZone == ZONE_LO) cand = DIR_DOWN;
    else if (xZone == ZONE_HI && yZone == ZONE_MID) cand = DIR_RIGHT;
    else if (xZone == ZONE_LO && yZone == ZONE_MID) cand = DIR_LEFT;
  end

  // Debounce: dir follows cand only after STABLE_N identical evaluations in a row.
  always_comb begin
    lastCandNext = lastCand;
    cntNext      = cnt;
    dirNext      = dir;
    if (evalPending) begin
      if (cand == lastCand) begin
        if (cnt < CNT_W'(STABLE_N)) cntNext = cnt + CNT_W'(1);
      end else begin
        lastCandNext = cand;
        cntNext      = CNT_W'(1);
      end
      if (cntNext == CNT_W'(STABLE_N) && cand != dir) dirNext = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastCand <= DIR_NONE;
      cnt      <= '0;
      dir      <= DIR_NONE;
    end else begin
      lastCand <= lastCandNext;
      cnt      <= cntNext;
      dir      <= dirNext;
    end
  end

`ifdef JSTK_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] repCnt, repCntNext, repInc;
  assign repInc = repCnt + REP_W'(1);
`endif

  // Move FSM reacts to the debounced dir of the same evaluation so the pulse lines up with dir.
  always_comb begin
    stateNext   = state;
    pulseNext   = 1'b0;
    moveDirNext = move_dir;
`ifdef JSTK_AUTOREPEAT_EN
    repCntNext  = repCnt;
`endif
    if (evalPending) begin
      if (dirNext != dir) begin
        if (dirNext == DIR_NONE) begin
          if (state != IDLE) stateNext = IDLE;
        end else begin
          pulseNext   = 1'b1;
          moveDirNext = dirNext[1:0];
          stateNext   = HOLD_DLY;
`ifdef JSTK_AUTOREPEAT_EN
          repCntNext  = '0;
`endif
        end
      end else begin
`ifdef JSTK_AUTOREPEAT_EN
        case (state)
          HOLD_DLY: begin
            if (repInc == REP_W'(REPEAT_DLY)) begin
              pulseNext  = 1'b1;
              repCntNext = '0;
              stateNext  = HOLD_REP;
            end else begin
              repCntNext = repInc;
            end
          end
          HOLD_REP: begin
            if (repInc == REP_W'(REPEAT_PER)) begin
              pulseNext  = 1'b1;
              repCntNext = '0;
            end else begin
              repCntNext = repInc;
            end
          end
          default: ;
        endcase
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      move_pulse <= 1'b0;
      move_dir   <= 2'd0;
`ifdef JSTK_AUTOREPEAT_EN
      repCnt     <= '0;
`endif
    end else begin
      state      <= stateNext;
      move_pulse <= pulseNext;
      move_dir   <= moveDirNext;
`ifdef JSTK_AUTOREPEAT_EN
      repCnt     <= repCntNext;
`endif
    end
  end

endmodule

// File: tb/tb_jstk_dir_decoder.sv
// Self-checking bench for jstk_dir_decoder: directed vector table, reset sequences,
// and randomized samples against a behavioural model (honours JSTK_AUTOREPEAT_EN).
module tb_jstk_dir_decoder;

  localparam int STABLE_N   = 3;
  localparam int REPEAT_DLY = 4;
  localparam int REPEAT_PER = 2;
  localparam int H          = 512 + 128;
  localparam int L          = 512 - 128;
  localparam int HYST       = 16;
  localparam bit AR =
`ifdef JSTK_AUTOREPEAT_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [9:0] x_raw = '0;
  logic [9:0] y_raw = '0;
  logic [2:0] dir;
  logic       move_pulse;
  logic [1:0] move_dir;

  always #5 clk = ~clk;

  jstk_dir_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .x_raw       (x_raw),
    .y_raw       (y_raw),
    .dir         (dir),
    .move_pulse  (move_pulse),
    .move_dir    (move_dir)
  );

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    bit doReset;
    int x;
    int y;
    int expDir;
    bit expPulse;
    int expMoveDir;
  } vec_t;

  vec_t vecs[$];

  // Reference model: zone per axis as -1/0/+1, candidate history, hold-evaluation count.
  int mXZone, mYZone, mDir, mMoveDir, mHoldN;
  bit mPulse;
  int mHist[$];

  function automatic int zoneStep(input int z, input int v);
    if (z == 1)  return (v < L) ? -1 : ((v < H - HYST) ? 0 : 1);
    if (z == -1) return (v > H) ? 1 : ((v > L + HYST) ? 0 : -1);
    return (v > H) ? 1 : ((v < L) ? -1 : 0);
  endfunction

  function automatic void modelReset();
    mXZone = 0; mYZone = 0; mDir = 4; mMoveDir = 0; mHoldN = 0; mPulse = 0;
    mHist.delete();
  endfunction

  function automatic void modelStep(input int x, input int y);
    int  cand, newDir;
    bit  same;
    mXZone = zoneStep(mXZone, x);
    mYZone = zoneStep(mYZone, y);
    if (mXZone == 0 && mYZone == 1)       cand = 0;
    else if (mXZone == 0 && mYZone == -1) cand = 1;
    else if (mXZone == 1 && mYZone == 0)  cand = 2;
    else if (mXZone == -1 && mYZone == 0) cand = 3;
    else                                  cand = 4;
    mHist.push_back(cand);
    if (mHist.size() > STABLE_N) void'(mHist.pop_front());
    newDir = mDir;
    if (mHist.size() == STABLE_N) begin
      same = 1;
      foreach (mHist[i]) if (mHist[i] != mHist[0]) same = 0;
      if (same && mHist[0] != mDir) newDir = mHist[0];
    end
    mPulse = 0;
    if (newDir != mDir) begin
      if (newDir != 4) begin
        mPulse = 1; mMoveDir = newDir; mHoldN = 0;
      end
      mDir = newDir;
    end else if (mDir != 4) begin
      mHoldN++;
      if (AR && (mHoldN == REPEAT_DLY ||
                 (mHoldN > REPEAT_DLY && (mHoldN - REPEAT_DLY) % REPEAT_PER == 0)))
        mPulse = 1;
    end
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One sample strobe, then outputs checked after the evaluation edge and the pulse checked low a cycle later.
  task automatic applyStimulus(input int x, input int y, input int eDir, input bit ePulse,
                               input int eMd, input string tag);
    @(negedge clk);
    sample_valid = 1'b1;
    x_raw = x[9:0];
    y_raw = y[9:0];
    @(negedge clk);
    sample_valid = 1'b0;
    x_raw = 10'($urandom);
    y_raw = 10'($urandom);
    @(posedge clk);
    #1;
    checkOutput({tag, " dir"}, int'(dir), eDir);
    checkOutput({tag, " move_pulse"}, int'(move_pulse), int'(ePulse));
    checkOutput({tag, " move_dir"}, int'(move_dir), eMd);
    @(posedge clk);
    #1;
    checkOutput({tag, " pulse_width"}, int'(move_pulse), 0);
  endtask

  function automatic void addVec(input bit r, input int x, input int y, input int d,
                                 input bit p, input int m);
    vec_t v;
    v.doReset = r; v.x = x; v.y = y; v.expDir = d; v.expPulse = p; v.expMoveDir = m;
    vecs.push_back(v);
  endfunction

  function automatic int pickVal();
    int edges[12];
    edges = '{383, 384, 385, 399, 400, 401, 623, 624, 625, 639, 640, 641};
    case ($urandom_range(0, 7))
      0, 1, 2: return int'($urandom_range(0, 1023));
      3:       return 512;
      4:       return 700;
      5:       return 300;
      default: return edges[$urandom_range(0, 11)];
    endcase
  endfunction

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int px, py;

    // Basic UP: pulse only after the third sample.
    addVec(1, 512, 700, 4, 0, 0);
    addVec(0, 512, 700, 4, 0, 0);
    addVec(0, 512, 700, 0, 1, 0);
    // RIGHT with hysteresis on the return toward centre.
    addVec(1, 650, 512, 4, 0, 0);
    addVec(0, 650, 512, 4, 0, 0);
    addVec(0, 650, 512, 2, 1, 2);
    for (int k = 0; k < 3; k++) addVec(0, 630, 512, 2, 0, 2);
    addVec(0, 620, 512, 2, AR, 2);
    addVec(0, 620, 512, 2, 0, 2);
    addVec(0, 620, 512, 4, 0, 2);
    // Debounce glitch.
    addVec(1, 512, 700, 4, 0, 0);
    addVec(0, 512, 700, 4, 0, 0);
    addVec(0, 512, 512, 4, 0, 0);
    addVec(0, 512, 700, 4, 0, 0);
    addVec(0, 512, 700, 4, 0, 0);
    addVec(0, 512, 700, 0, 1, 0);
    // Diagonal and exact thresholds.
    addVec(1, 700, 700, 4, 0, 0);
    for (int k = 0; k < 4; k++) addVec(0, 700, 700, 4, 0, 0);
    addVec(1, 640, 512, 4, 0, 0);
    for (int k = 0; k < 2; k++) addVec(0, 640, 512, 4, 0, 0);
    for (int k = 0; k < 3; k++) addVec(0, 512, 384, 4, 0, 0);
    addVec(0, 641, 512, 4, 0, 0);
    addVec(0, 641, 512, 4, 0, 0);
    addVec(0, 641, 512, 2, 1, 2);
    // Held UP for 12 samples, then LEFT.
    for (int k = 1; k <= 12; k++)
      addVec(k == 1, 512, 700, (k >= 3) ? 0 : 4,
             (k == 3) || (AR && (k == 7 || k == 9 || k == 11)), 0);
    addVec(0, 300, 512, 0, AR, 0);
    addVec(0, 300, 512, 0, 0, 0);
    addVec(0, 300, 512, 3, 1, 3);

    applyReset();
    #1;
    checkOutput("reset dir", int'(dir), 4);
    checkOutput("reset move_pulse", int'(move_pulse), 0);
    checkOutput("reset move_dir", int'(move_dir), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].doReset) applyReset();
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].expDir, vecs[i].expPulse,
                    vecs[i].expMoveDir, $sformatf("vec%0d", i));
    end

    // Reset while a repeat evaluation is pending must drop it.
    applyReset();
    for (int k = 1; k <= 8; k++)
      applyStimulus(512, 700, (k >= 3) ? 0 : 4, (k == 3) || (AR && k == 7), 0,
                    $sformatf("hold%0d", k));
    @(negedge clk);
    sample_valid = 1'b1; x_raw = 10'd512; y_raw = 10'd700;
    @(negedge clk);
    sample_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstHold dir", int'(dir), 4);
    checkOutput("rstHold move_pulse", int'(move_pulse), 0);
    checkOutput("rstHold move_dir", int'(move_dir), 0);
    // A strobe during reset must not move the X zone to LO.
    @(negedge clk);
    sample_valid = 1'b1; x_raw = 10'd300; y_raw = 10'd512;
    @(negedge clk);
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstStrobe move_pulse", int'(move_pulse), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("postRst%0d move_pulse", k), int'(move_pulse), 0);
    end
    for (int k = 1; k <= 3; k++)
      applyStimulus(390, 512, 4, 0, 0, $sformatf("ignored%0d", k));
    for (int k = 1; k <= 3; k++)
      applyStimulus(512, 700, (k == 3) ? 0 : 4, k == 3, 0, $sformatf("reUp%0d", k));

    // Randomized samples against the model.
    applyReset();
    modelReset();
    px = 512; py = 512;
    for (int i = 0; i < 300; i++) begin
      if (i == 0 || $urandom_range(0, 2) == 0) begin
        px = pickVal();
        py = pickVal();
      end
      modelStep(px, py);
      applyStimulus(px, py, mDir, mPulse, mMoveDir, $sformatf("rnd%0d(%0d,%0d)", i, px, py));
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
